// File: rtl/percept_pkg.sv
`default_nettype none
// ============================================================================
// Module   : percept_pkg
// Purpose  : Shared definitions for the perceptron node serial interface.
//            Holds the transmitter FSM state type and the line levels. The
//            node receiver uses the same levels, so both sides agree on what
//            idle, start and pad look like on the wire.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package percept_pkg;

   localparam int   ADDR_BITS   = 8;
   localparam logic IDLE_LEVEL  = 1'b1;
   localparam logic START_LEVEL = 1'b0;
   localparam logic PAD_LEVEL   = 1'b1;

   // Each state names the symbol currently on the line.
   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_START = 3'd1,
      ST_ADDR  = 3'd2,
      ST_PAD   = 3'd3,
      ST_DATA  = 3'd4,
      ST_GAP   = 3'd5
   } tx_state_t;

endpackage : percept_pkg
`default_nettype wire

// File: rtl/percept_byte_hold.sv
`default_nettype none
// ============================================================================
// Module   : percept_byte_hold
// Purpose  : Single-entry byte holding register between the payload byte
//            stream and the transmitter shift register.
// Ports    : clk      in   clock, rising edge
//            nRst     in   synchronous active-low reset
//            wr_data  in   incoming byte
//            wr_valid in   incoming byte valid
//            wr_ready out  register empty; byte accepted on wr_valid&&wr_ready
//            take     in   consumer removes the held byte this cycle
//            rd_data  out  held byte
//            full     out  a byte is held
// Revision : 1.0 - initial release
// ============================================================================
module percept_byte_hold (
   input  logic       clk,
   input  logic       nRst,
   input  logic [7:0] wr_data,
   input  logic       wr_valid,
   output logic       wr_ready,
   input  logic       take,
   output logic [7:0] rd_data,
   output logic       full
);

   // Ready depends only on the registered full flag. A take empties the
   // register at the edge, so a byte offered in the same cycle cannot pass
   // straight through: it lands one cycle later and waits for the next take.
   assign wr_ready = ~full;

   always_ff @(posedge clk) begin
      if (!nRst) begin
         full    <= 1'b0;
         rd_data <= 8'h00;
      end else if (take) begin
         full    <= 1'b0;
      end else if (wr_valid && !full) begin
         full    <= 1'b1;
         rd_data <= wr_data;
      end
   end

endmodule : percept_byte_hold
`default_nettype wire

// File: rtl/percept_frame_tx.sv
`default_nettype none
// ============================================================================
// Module   : percept_frame_tx
// Purpose  : Host-side serial frame transmitter for perceptron nodes. Sends
//            start bit, 8-bit address (MSB first), pad bit, PAYLOAD_BITS
//            payload bits from a byte stream, then IDLE_GAP idle-high cycles.
// Ports    : clk          in   clock, rising edge
//            nRst         in   synchronous active-low reset
//            start        in   frame request (taken when start_ready=1)
//            addr         in   node address, captured on acceptance
//            start_ready  out  idle and a payload byte is held
//            data_in      in   payload byte, MSB sent first
//            data_valid   in   data_in valid
//            data_ready   out  holding register empty
//            serial_out   out  registered serial line, idles high
//            busy         out  frame in progress
//            done         out  one-cycle pulse when the frame ends
//            err_underrun out  sticky payload underrun, cleared on next start
// Revision : 1.0 - initial release
// ============================================================================
module percept_frame_tx
   import percept_pkg::*;
#(
   parameter int PAYLOAD_BITS = 129,
   parameter int IDLE_GAP     = 2
) (
   input  logic                 clk,
   input  logic                 nRst,
   input  logic                 start,
   input  logic [ADDR_BITS-1:0] addr,
   output logic                 start_ready,
   input  logic [7:0]           data_in,
   input  logic                 data_valid,
   output logic                 data_ready,
   output logic                 serial_out,
   output logic                 busy,
   output logic                 done,
   output logic                 err_underrun
);

   localparam int BIT_CW  = $clog2(PAYLOAD_BITS + 1);
   localparam int GAP_CW  = $clog2(IDLE_GAP + 1);
   localparam int ADDR_CW = $clog2(ADDR_BITS);

   localparam logic [BIT_CW-1:0]  PAY_DONE  = BIT_CW'(PAYLOAD_BITS);
   localparam logic [BIT_CW-1:0]  LAST_BIT  = BIT_CW'(PAYLOAD_BITS - 1);
   localparam logic [GAP_CW-1:0]  GAP_LAST  = GAP_CW'(IDLE_GAP);
   localparam logic [ADDR_CW-1:0] ADDR_LAST = ADDR_CW'(ADDR_BITS - 1);

   tx_state_t              state, state_nx;
   logic [ADDR_BITS-1:0]   addr_sh, addr_sh_nx;
   logic [ADDR_CW-1:0]     addr_cnt, addr_cnt_nx;
   logic [7:0]             pay_sh, pay_sh_nx;
   logic [BIT_CW-1:0]      bit_cnt, bit_cnt_nx;
   logic [2:0]             bit_pos, bit_pos_nx;
   logic [GAP_CW-1:0]      gap_cnt, gap_cnt_nx;
   logic                   line_nx;
   logic                   done_nx;
   logic                   err_nx;

   logic                   take;
   logic [7:0]             hold_data;
   logic                   hold_full;
   logic                   accept;
   logic                   reload_due;

   percept_byte_hold u_hold (
      .clk      (clk),
      .nRst     (nRst),
      .wr_data  (data_in),
      .wr_valid (data_valid),
      .wr_ready (data_ready),
      .take     (take),
      .rd_data  (hold_data),
      .full     (hold_full)
   );

   assign busy        = (state != ST_IDLE);
   assign start_ready = (state == ST_IDLE) && hold_full;
   assign accept      = start && start_ready;

   // A new byte is needed once the 8th bit of the current byte goes out,
   // unless that bit is the final payload bit of the frame. Any unsent low
   // bits of a partial last byte are simply never shifted out.
   assign reload_due  = (bit_pos == 3'd7) && (bit_cnt != LAST_BIT);

   always_comb begin
      state_nx    = state;
      line_nx     = serial_out;
      addr_sh_nx  = addr_sh;
      addr_cnt_nx = addr_cnt;
      pay_sh_nx   = pay_sh;
      bit_cnt_nx  = bit_cnt;
      bit_pos_nx  = bit_pos;
      gap_cnt_nx  = gap_cnt;
      done_nx     = 1'b0;
      err_nx      = err_underrun;
      take        = 1'b0;

      case (state)
         ST_IDLE: begin
            line_nx = IDLE_LEVEL;
            if (accept) begin
               state_nx    = ST_START;
               line_nx     = START_LEVEL;
               addr_sh_nx  = addr;
               pay_sh_nx   = hold_data;
               take        = 1'b1;
               err_nx      = 1'b0;
               bit_cnt_nx  = '0;
               bit_pos_nx  = 3'd0;
               gap_cnt_nx  = '0;
               addr_cnt_nx = '0;
            end
         end

         ST_START: begin
            state_nx    = ST_ADDR;
            line_nx     = addr_sh[ADDR_BITS-1];
            addr_sh_nx  = {addr_sh[ADDR_BITS-2:0], 1'b0};
            addr_cnt_nx = '0;
         end

         ST_ADDR: begin
            if (addr_cnt == ADDR_LAST) begin
               state_nx   = ST_PAD;
               line_nx    = PAD_LEVEL;
               bit_cnt_nx = '0;
               bit_pos_nx = 3'd0;
            end else begin
               line_nx     = addr_sh[ADDR_BITS-1];
               addr_sh_nx  = {addr_sh[ADDR_BITS-2:0], 1'b0};
               addr_cnt_nx = addr_cnt + ADDR_CW'(1);
            end
         end

         // Leaving PAD emits payload bit 0; DATA emits the rest until the
         // bit counter shows every payload bit has been placed on the line.
         ST_PAD, ST_DATA: begin
            if ((state == ST_DATA) && (bit_cnt == PAY_DONE)) begin
               state_nx   = ST_GAP;
               line_nx    = IDLE_LEVEL;
               gap_cnt_nx = GAP_CW'(1);
            end else begin
               state_nx   = ST_DATA;
               line_nx    = pay_sh[7];
               bit_cnt_nx = bit_cnt + BIT_CW'(1);
               bit_pos_nx = bit_pos + 3'd1;
               if (reload_due) begin
                  // The line has no flow control: on underrun send zeros
                  // and flag it rather than stretching the frame.
                  take      = hold_full;
                  pay_sh_nx = hold_full ? hold_data : 8'h00;
                  if (!hold_full) begin
                     err_nx = 1'b1;
                  end
               end else begin
                  pay_sh_nx = {pay_sh[6:0], 1'b0};
               end
            end
         end

         ST_GAP: begin
            line_nx = IDLE_LEVEL;
            if (gap_cnt == GAP_LAST) begin
               state_nx = ST_IDLE;
               done_nx  = 1'b1;
            end else begin
               gap_cnt_nx = gap_cnt + GAP_CW'(1);
            end
         end

         default: begin
            state_nx = ST_IDLE;
            line_nx  = IDLE_LEVEL;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!nRst) begin
         state        <= ST_IDLE;
         serial_out   <= IDLE_LEVEL;
         addr_sh      <= '0;
         addr_cnt     <= '0;
         pay_sh       <= 8'h00;
         bit_cnt      <= '0;
         bit_pos      <= 3'd0;
         gap_cnt      <= '0;
         done         <= 1'b0;
         err_underrun <= 1'b0;
      end else begin
         state        <= state_nx;
         serial_out   <= line_nx;
         addr_sh      <= addr_sh_nx;
         addr_cnt     <= addr_cnt_nx;
         pay_sh       <= pay_sh_nx;
         bit_cnt      <= bit_cnt_nx;
         bit_pos      <= bit_pos_nx;
         gap_cnt      <= gap_cnt_nx;
         done         <= done_nx;
         err_underrun <= err_nx;
      end
   end

endmodule : percept_frame_tx
`default_nettype wire
